fp_mult_result_buffer: RTL and testbench
========================================

// Module: fp_mult_result_buffer
// PURPOSE
//   Output stage directly downstream of the combinational FP32 multiplier.
//   Captures each product word {result, inf, nan, zero, overflow, underflow} on a valid/ready
//   handshake into a first-word-fall-through FIFO and presents it to the consumer.
//   Also keeps IEEE-style sticky exception status and a saturating exception-event counter.
// PARAMETERS
//   DEPTH  4  FIFO entries; power of two, >= 2
//   CNT_W  8  width of exc_count
// PORTS
//   clk         in   1                  rising-edge clock
//   reset_n     in   1                  synchronous, active-low reset
//   in_valid    in   1                  multiplier output word is valid
//   in_ready    out  1                  buffer can accept a word this cycle
//   in_result   in   32                 FP32 product from multiplier
//   in_flags    in   5                  {inf, nan, zero, overflow, underflow} from multiplier
//   out_valid   out  1                  head entry available
//   out_ready   in   1                  consumer takes head entry
//   out_result  out  32                 head entry result
//   out_flags   out  5                  head entry flags, same bit order as in_flags
//   count       out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//   sticky      out  5                  OR of flags of all accepted words since reset/clear
//   flag_err    out  1                  sticky: an accepted word had more than one flag set
//   sticky_clr  in   1                  clears sticky, flag_err and exc_count
//   exc_count   out  CNT_W              accepted words with inf|nan|overflow|underflow; saturating
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): count=0, rd/wr pointers=0, sticky=0, flag_err=0,
//     exc_count=0, out_valid=0. Contents discarded; reset mid-stream drops all entries.
//   in_ready = (count != DEPTH). It is combinational from state only; it does not depend on
//     out_ready. At full, a same-cycle pop does not allow a push.
//   Push: in_valid & in_ready at an edge. Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
//   Pop: out_valid & out_ready at an edge. Increments rd_ptr modulo DEPTH.
//   Occupancy: push and pop in the same cycle leaves count unchanged. Otherwise count changes by +/-1.
//   out_valid = (count != 0).
//   out_result/out_flags = mem[rd_ptr] when out_valid=1. They are forced to 0 when out_valid=0.
//   Latency: a word pushed into an empty buffer appears at the outputs the cycle after the push edge.
//   Data is never modified; words are passed bit-exact and in order.
//   sticky: on push, sticky <= sticky | in_flags.
//     With sticky_clr=1 in the same cycle: sticky <= in_flags if a push occurs, else 0 (set wins).
//   flag_err: set on push when popcount(in_flags) > 1. Cleared by sticky_clr with the same
//     set-wins rule.
//   exc_count: on push with |{inf,nan,overflow,underflow} (zero flag excluded), increment by 1,
//     saturating at 2^CNT_W-1.
//     sticky_clr with an exceptional push in the same cycle -> 1; sticky_clr alone -> 0.
//   in_valid without in_ready: word not captured; no status update. The upstream stage holds
//     the word.
//   Pointer wrap: rd_ptr/wr_ptr wrap DEPTH-1 -> 0. Full/empty are derived from count, not from
//     the pointers.
// TESTING
//   1. Reset, push 0x40C00000 flags 5'b00000 (2.0*3.0), out_ready=1 -> next cycle
//      out_valid=1, out_result=0x40C00000; popped at that edge; count returns to 0.
//   2. out_ready=0, push 5 words back-to-back -> in_ready=0 after 4th push, count=4;
//      5th word is not stored; drain yields words 1-4 in order.
//   3. Buffer full, in_valid=1 and out_ready=1 together -> pop only, count=3; push accepted
//      the following cycle.
//   4. Push flags 5'b01000 (nan), then 5'b00001 (underflow) -> sticky=5'b01001, exc_count=2;
//      a zero-flag word leaves exc_count=2.
//   5. sticky_clr=1 in the same cycle as a push with flags 5'b10000 -> sticky=5'b10000,
//      exc_count=1, flag_err=0.
//   6. CNT_W=2: push 5 overflow words -> exc_count saturates at 3; flags 5'b00110 pushed ->
//      flag_err=1; reset mid-stream -> count=0, out_valid=0.

Source files
------------

// File: rtl/fp_mult_result_buffer.sv
// Result buffer behind the FP32 multiplier: first-word-fall-through FIFO of product words
// plus sticky exception status, a multi-flag error bit and a saturating exception counter.
module fp_mult_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic [4:0]                 in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [4:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic [4:0]                 sticky,
    output logic                       flag_err,
    input  logic                       sticky_clr,
    output logic [CNT_W-1:0]           exc_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Handshakes: a word moves on an edge where valid and ready are both high; the
    // producer holds its word while ready is low. in_ready depends on occupancy only.

    logic [36:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [4:0]       sticky_q, sticky_d;
    logic             flag_err_q, flag_err_d;
    logic [CNT_W-1:0] exc_q, exc_d;

    logic push, pop, multi_flag, exc_event;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // More than one flag set: clearing the lowest set bit leaves something behind.
    assign multi_flag = (in_flags & (in_flags - 5'd1)) != 5'd0;
    // The zero flag is a legitimate result, not an exception.
    assign exc_event  = push & (in_flags[4] | in_flags[3] | in_flags[1] | in_flags[0]);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        flag_err_d = flag_err_q;
        exc_d      = exc_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // Clear and a same-cycle push: the pushed word's status survives the clear.
        if (sticky_clr) begin
            sticky_d   = push ? in_flags : 5'd0;
            flag_err_d = push & multi_flag;
            exc_d      = exc_event ? CNT_W'(1) : '0;
        end else begin
            if (push) sticky_d = sticky_q | in_flags;
            if (push && multi_flag) flag_err_d = 1'b1;
            if (exc_event && exc_q != CNT_MAX) exc_d = exc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_q   <= '0;
            flag_err_q <= 1'b0;
            exc_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            flag_err_q <= flag_err_d;
            exc_q      <= exc_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_result, in_flags};
    end

    assign out_result = out_valid ? mem_q[rd_ptr_q][36:5] : 32'd0;
    assign out_flags  = out_valid ? mem_q[rd_ptr_q][4:0]  : 5'd0;
    assign count      = count_q;
    assign sticky     = sticky_q;
    assign flag_err   = flag_err_q;
    assign exc_count  = exc_q;

endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// Directed bench for fp_mult_result_buffer: driver tasks feed product words, a monitor pops
// the expected queue on every output handshake, status is checked against hand values.
module tb_fp_mult_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_result;
    logic [4:0]        in_flags;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [4:0]        out_flags;
    logic [2:0]        count;
    logic [4:0]        sticky;
    logic              flag_err;
    logic              sticky_clr;
    logic [CNT_W-1:0]  exc_count;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    fp_mult_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .count      (count),
        .sticky     (sticky),
        .flag_err   (flag_err),
        .sticky_clr (sticky_clr),
        .exc_count  (exc_count)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare the head word on every output handshake, idle outputs must be zero.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected actual=%0h required=none", {out_result, out_flags});
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_word", {out_result, out_flags}, e);
                end
            end else if (reset_n && !out_valid) begin
                chk("idle_zero", {out_result, out_flags}, 0);
            end
        end
    end

    // Driver tasks: all start and end one time unit after a rising edge.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] f, input logic clr, input logic acc);
        in_valid   = 1'b1;
        in_result  = r;
        in_flags   = f;
        sticky_clr = clr;
        @(negedge clk);
        chk("in_ready", in_ready, acc);
        if (acc) exp_q.push_back({r, f});
        settle();
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        sticky_clr = 1'b0;
    endtask

    task automatic status(input logic [4:0] s, input logic fe, input logic [CNT_W-1:0] ec);
        @(negedge clk);
        chk("sticky", sticky, s);
        chk("flag_err", flag_err, fe);
        chk("exc_count", exc_count, ec);
        settle();
    endtask

    task automatic drain();
        bit done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (count == 0) done = 1;
            else settle();
        end
        chk("drain_done", done, 1);
        chk("drain_queue_empty", exp_q.size(), 0);
        settle();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        settle();
        settle();
        reset_n = 1'b1;
    endtask

    initial begin
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        sticky_clr = 1'b0;
        out_ready  = 1'b0;
        reset_n    = 1'b0;
        settle();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        settle();
        status(5'b00000, 1'b0, 2'd0);

        // Single word through an empty buffer, popped the cycle it appears
        out_ready = 1'b1;
        push(32'h40C00000, 5'b00000, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_result", out_result, 32'h40C00000);
        settle();
        @(negedge clk);
        chk("t1_count", count, 0);
        settle();

        // Fill to full; the fifth word (carrying a nan flag) must be refused
        out_ready = 1'b0;
        push(32'h3F800000, 5'b00000, 1'b0, 1'b1);
        push(32'h40000000, 5'b00000, 1'b0, 1'b1);
        push(32'h40400000, 5'b00000, 1'b0, 1'b1);
        push(32'h40800000, 5'b00000, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_count_full", count, 4);
        chk("t2_in_ready_full", in_ready, 0);
        settle();
        push(32'h7FC00000, 5'b01000, 1'b0, 1'b0);

        // Full with push and pop requested together: only the pop happens
        in_valid  = 1'b1;
        in_result = 32'h41000000;
        in_flags  = 5'b00000;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready", in_ready, 0);
        settle();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t3_count_after_pop", count, 3);
        chk("t3_in_ready_after_pop", in_ready, 1);
        exp_q.push_back({32'h41000000, 5'b00000});
        settle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_count_refill", count, 4);
        settle();
        drain();
        status(5'b00000, 1'b0, 2'd0);

        // Sticky and counter accumulation; zero flag is not an exception
        out_ready = 1'b1;
        push(32'h7FC00000, 5'b01000, 1'b0, 1'b1);
        push(32'h00000001, 5'b00001, 1'b0, 1'b1);
        status(5'b01001, 1'b0, 2'd2);
        push(32'h00000000, 5'b00100, 1'b0, 1'b1);
        status(5'b01101, 1'b0, 2'd2);

        // Clear together with an inf push: the push's status survives
        push(32'h7F800000, 5'b10000, 1'b1, 1'b1);
        status(5'b10000, 1'b0, 2'd1);
        sticky_clr = 1'b1;
        settle();
        sticky_clr = 1'b0;
        status(5'b00000, 1'b0, 2'd0);

        // Counter saturation, multi-flag error
        for (int i = 0; i < 3; i++) push(32'h7F800000, 5'b00010, 1'b0, 1'b1);
        status(5'b00010, 1'b0, 2'd3);
        for (int i = 0; i < 2; i++) push(32'h7F800000, 5'b00010, 1'b0, 1'b1);
        status(5'b00010, 1'b0, 2'd3);
        push(32'h00000000, 5'b00110, 1'b0, 1'b1);
        status(5'b00110, 1'b1, 2'd3);
        drain();

        // Reset mid-stream drops buffered words and status
        push(32'h3F800000, 5'b01000, 1'b0, 1'b1);
        push(32'h40000000, 5'b00000, 1'b0, 1'b1);
        do_reset();
        @(negedge clk);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        settle();
        status(5'b00000, 1'b0, 2'd0);

        // Buffer works again after the mid-stream reset
        push(32'h3FC00000, 5'b00000, 1'b0, 1'b1);
        push(32'hBF800000, 5'b00000, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
